fifo_read_arbiter: RTL and testbench



---
 rtl/fifo_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 50 +++++
 rtl/fifo_read_arbiter.sv | 135 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read arbiter: FSM encoding and a
// constant-evaluable ceiling-log2 used to size counters and indices.
package fifo_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Ceiling log2, usable in parameter and localparam expressions.
   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the previous
// winner. Requests are rotated so that position becomes bit 0, the lowest set
// bit is found, and the result is rotated back to a real FIFO index.
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_FIFO = 4,
   parameter int IDW      = clog2(NUM_FIFO)
) (
   input  logic [NUM_FIFO-1:0] req,
   input  logic [IDW-1:0]      last_grant,
   output logic [IDW-1:0]      gnt_idx,
   output logic                gnt_any
);

   localparam logic [IDW:0] N_EXT = (IDW+1)'(NUM_FIFO);

   logic [IDW-1:0]      start;
   logic [NUM_FIFO-1:0] rot;
   logic [IDW-1:0]      enc;
   logic [IDW:0]        usum;

   // Search origin wraps from the last FIFO back to FIFO 0.
   assign start = (last_grant == IDW'(NUM_FIFO - 1)) ? '0 : last_grant + 1'b1;

   // Rotate requests so the search origin lands on bit 0.
   for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_rot
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      assign sum     = {1'b0, start} + (IDW+1)'(gi);
      assign idx     = (sum >= N_EXT) ? IDW'(sum - N_EXT) : IDW'(sum);
      assign rot[gi] = req[idx];
   end

   // Lowest set bit of the rotated vector wins.
   always_comb begin
      enc     = '0;
      gnt_any = |rot;
      for (int i = NUM_FIFO - 1; i >= 0; i--) begin
         if (rot[i]) begin
            enc = IDW'(i);
         end
      end
   end

   // Undo the rotation to recover the physical FIFO index.
   assign usum    = {1'b0, enc} + {1'b0, start};
   assign gnt_idx = (usum >= N_EXT) ? IDW'(usum - N_EXT) : IDW'(usum);

endmodule

// File: rtl/fifo_read_arbiter.sv
// Read-domain arbiter draining several FWFT FIFOs into one valid/ready
// stream. FIFOs are granted round-robin and drained in bursts of up to
// BURST_MAX words; each output word carries its source FIFO index.
module fifo_read_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_FIFO  = 4,
   parameter int DSIZE     = 8,
   parameter int BURST_MAX = 8,
   parameter int IDW       = 2
) (
   input  logic                      rclk,
   input  logic                      rrst,
   input  logic [NUM_FIFO-1:0]       rempty,
   input  logic [NUM_FIFO*DSIZE-1:0] rdata,
   output logic [NUM_FIFO-1:0]       rinc,
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic [DSIZE-1:0]          o_data,
   output logic [IDW-1:0]            o_id,
   output logic                      o_last,
   output logic                      busy
);

   localparam int            CW       = clog2(BURST_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

   state_t         state_reg, state_next;
   logic [IDW-1:0] grant_reg, grant_next;
   logic [IDW-1:0] last_grant_reg, last_grant_next;
   logic [CW-1:0]  cnt_reg, cnt_next;

   logic             o_valid_reg;
   logic [DSIZE-1:0] o_data_reg;
   logic [IDW-1:0]   o_id_reg;
   logic             o_last_reg;

   logic [DSIZE-1:0] rdata_arr [NUM_FIFO];
   logic [IDW-1:0]   arb_idx;
   logic             arb_any;
   logic             pop;
   logic             at_last;

   // Unpack the flat read-data bus into per-FIFO words.
   for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_unpack
      assign rdata_arr[gi] = rdata[gi*DSIZE +: DSIZE];
   end

   rr_arbiter #(
      .NUM_FIFO (NUM_FIFO),
      .IDW      (IDW)
   ) u_rr (
      .req        (~rempty),
      .last_grant (last_grant_reg),
      .gnt_idx    (arb_idx),
      .gnt_any    (arb_any)
   );

   // A pop needs data in the granted FIFO and a free (or draining) output slot.
   assign pop     = (state_reg == ST_BURST) && !rempty[grant_reg] && (!o_valid_reg || o_ready);
   assign at_last = (cnt_reg == CNT_LAST);

   // Only the granted FIFO's strobe can ever be high.
   for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_rinc
      assign rinc[gi] = pop && (grant_reg == IDW'(gi));
   end

   // Next-state: arbitrate in IDLE, count pops in BURST, leave on full burst or empty.
   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (arb_any) begin
               state_next = ST_BURST;
               grant_next = arb_idx;
               cnt_next   = '0;
            end
         end
         ST_BURST: begin
            if (rempty[grant_reg]) begin
               state_next      = ST_IDLE;
               last_grant_next = grant_reg;
            end else if (pop) begin
               cnt_next = cnt_reg + 1'b1;
               if (at_last) begin
                  state_next      = ST_IDLE;
                  last_grant_next = grant_reg;
               end
            end
         end
      endcase
   end

   // FSM and arbitration state registers.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         state_reg      <= ST_IDLE;
         grant_reg      <= '0;
         last_grant_reg <= IDW'(NUM_FIFO - 1);
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
      end
   end

   // Output register: load on pop, hold while stalled, clear valid once taken.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         o_valid_reg <= 1'b0;
         o_data_reg  <= '0;
         o_id_reg    <= '0;
         o_last_reg  <= 1'b0;
      end else if (pop) begin
         o_valid_reg <= 1'b1;
         o_data_reg  <= rdata_arr[grant_reg];
         o_id_reg    <= grant_reg;
         o_last_reg  <= at_last;
      end else if (o_ready) begin
         o_valid_reg <= 1'b0;
      end
   end

   assign o_valid = o_valid_reg;
   assign o_data  = o_data_reg;
   assign o_id    = o_id_reg;
   assign o_last  = o_last_reg;
   assign busy    = (state_reg == ST_BURST);

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter. Two instances (BURST_MAX 8 and 4)
// share one set of modelled FWFT FIFOs; sel chooses which one drains them.
module tb_fifo_read_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic              rclk = 1'b0;
   logic              rrst = 1'b1;
   logic [N-1:0]      rempty;
   logic [N*DW-1:0]   rdata;
   logic              o_ready;
   logic              sel;

   logic [N-1:0]  rinc_a, rinc_b, rinc_obs;
   logic          o_valid_a, o_valid_b, o_valid_obs;
   logic [DW-1:0] o_data_a, o_data_b, o_data_obs;
   logic [IW-1:0] o_id_a, o_id_b, o_id_obs;
   logic          o_last_a, o_last_b, o_last_obs;
   logic          busy_a, busy_b, busy_obs;

   always #5 rclk = ~rclk;

   fifo_read_arbiter #(.NUM_FIFO(N), .DSIZE(DW), .BURST_MAX(8), .IDW(IW)) u_arb8 (
      .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_a),
      .o_valid(o_valid_a), .o_ready(o_ready), .o_data(o_data_a), .o_id(o_id_a),
      .o_last(o_last_a), .busy(busy_a)
   );

   fifo_read_arbiter #(.NUM_FIFO(N), .DSIZE(DW), .BURST_MAX(4), .IDW(IW)) u_arb4 (
      .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_b),
      .o_valid(o_valid_b), .o_ready(o_ready), .o_data(o_data_b), .o_id(o_id_b),
      .o_last(o_last_b), .busy(busy_b)
   );

   always_comb begin
      rinc_obs    = sel ? rinc_b    : rinc_a;
      o_valid_obs = sel ? o_valid_b : o_valid_a;
      o_data_obs  = sel ? o_data_b  : o_data_a;
      o_id_obs    = sel ? o_id_b    : o_id_a;
      o_last_obs  = sel ? o_last_b  : o_last_a;
      busy_obs    = sel ? busy_b    : busy_a;
   end

   typedef struct {
      logic [7:0] data;
      logic [1:0] id;
      logic       last;
      int         cyc;
   } word_t;

   logic [7:0] fq [N][$];
   word_t      olog [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc;
   int         rinc_err = 0;
   int         pulse_cnt [N];
   int         first_pulse0;
   logic [14:0] busy_tr;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive_fifo();
      for (int i = 0; i < N; i++) begin
         rempty[i] = (fq[i].size() == 0);
         rdata[i*DW +: DW] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
      end
   endtask

   // One clock: sample strobes/handshake, clock edge, update FIFO model.
   task automatic tick();
      logic [N-1:0] rc;
      word_t        w;
      rc = rinc_obs;
      if ($countones(rc) > 1) rinc_err++;
      for (int i = 0; i < N; i++) begin
         if (rc[i]) begin
            pulse_cnt[i]++;
            if (fq[i].size() == 0) rinc_err++;
         end
      end
      if (rc[0] && first_pulse0 < 0) first_pulse0 = cyc;
      if (o_valid_obs && o_ready) begin
         w.data = o_data_obs; w.id = o_id_obs; w.last = o_last_obs; w.cyc = cyc;
         olog.push_back(w);
         $display("cyc %0d word data=%02h id=%0d last=%0b", cyc, w.data, w.id, w.last);
      end
      @(posedge rclk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rc[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      end
      drive_fifo();
      cyc++;
      @(negedge rclk);
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      for (int i = 0; i < N; i++) fq[i].delete();
      drive_fifo();
      @(negedge rclk);
      @(negedge rclk);
   endtask

   task automatic release_reset();
      drive_fifo();
      olog.delete();
      for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
      first_pulse0 = -1;
      cyc = 0;
      rrst = 1'b0;
      #1;
   endtask

   initial begin
      sel = 1'b0;
      o_ready = 1'b1;
      for (int i = 0; i < N; i++) fq[i].delete();
      drive_fifo();

      // ---- reset state, then FIFO0 holding three words ----
      do_reset();
      check_val("rst_o_valid", o_valid_obs, 0);
      check_val("rst_o_data", o_data_obs, 0);
      check_val("rst_o_id", o_id_obs, 0);
      check_val("rst_o_last", o_last_obs, 0);
      check_val("rst_busy", busy_obs, 0);
      check_val("rst_rinc", rinc_obs, 0);
      check_val("rst_last_grant", u_arb8.last_grant_reg, 3);
      fq[0].push_back(8'hA1); fq[0].push_back(8'hB2); fq[0].push_back(8'hC3);
      release_reset();
      for (int k = 0; k < 10; k++) tick();
      check_val("t1_first_pulse", first_pulse0, 1);
      check_val("t1_pulses", pulse_cnt[0], 3);
      check_val("t1_nwords", olog.size(), 3);
      if (olog.size() == 3) begin
         check_val("t1_w0", olog[0].data, 8'hA1);
         check_val("t1_w1", olog[1].data, 8'hB2);
         check_val("t1_w2", olog[2].data, 8'hC3);
         for (int k = 0; k < 3; k++) begin
            check_val("t1_id", olog[k].id, 0);
            check_val("t1_last", olog[k].last, 0);
         end
      end
      check_val("t1_last_grant", u_arb8.last_grant_reg, 0);
      check_val("t1_busy_end", busy_obs, 0);

      // ---- four FIFOs, 20 words each: 8,8,4-word bursts in rotation ----
      do_reset();
      for (int f = 0; f < N; f++)
         for (int k = 0; k < 20; k++) fq[f].push_back(8'(f*32 + k));
      release_reset();
      for (int k = 0; k < 400 && olog.size() < 80; k++) tick();
      check_val("t2_nwords", olog.size(), 80);
      begin
         int idx, fidx [N];
         int lens [3];
         lens[0] = 8; lens[1] = 8; lens[2] = 4;
         idx = 0;
         for (int f = 0; f < N; f++) fidx[f] = 0;
         for (int r = 0; r < 3; r++)
            for (int f = 0; f < N; f++)
               for (int k = 0; k < lens[r]; k++) begin
                  if (idx < olog.size()) begin
                     check_val("t2_data", olog[idx].data, 8'(f*32 + fidx[f]));
                     check_val("t2_id", olog[idx].id, f);
                     check_val("t2_last", olog[idx].last, (lens[r] == 8 && k == 7) ? 1 : 0);
                  end
                  fidx[f]++;
                  idx++;
               end
      end
      for (int f = 0; f < N; f++) check_val("t2_drained", fq[f].size(), 0);

      // ---- backpressure: o_ready low for 5 cycles mid-burst from FIFO1 ----
      do_reset();
      for (int k = 0; k < 6; k++) fq[1].push_back(8'(8'h10 + k));
      release_reset();
      for (int c = 0; c < 20; c++) begin
         o_ready = !(c >= 4 && c < 9);
         #1;
         if (c >= 4 && c < 9) begin
            check_val("t3_hold_valid", o_valid_obs, 1);
            check_val("t3_hold_data", o_data_obs, 8'h12);
            check_val("t3_hold_id", o_id_obs, 1);
            check_val("t3_hold_rinc", rinc_obs, 0);
         end
         tick();
      end
      o_ready = 1'b1;
      check_val("t3_nwords", olog.size(), 6);
      if (olog.size() == 6) begin
         for (int k = 0; k < 6; k++) check_val("t3_data", olog[k].data, 8'(8'h10 + k));
         check_val("t3_resume_cyc", olog[2].cyc, 9);
         check_val("t3_throughput", olog[5].cyc - olog[2].cyc, 3);
      end

      // ---- BURST_MAX=4, only FIFO2 non-empty with 10 words ----
      sel = 1'b1;
      do_reset();
      for (int k = 0; k < 10; k++) fq[2].push_back(8'(8'h40 + k));
      release_reset();
      for (int c = 0; c < 15; c++) begin
         busy_tr[c] = busy_obs;
         tick();
      end
      check_val("t4_busy_trace", busy_tr, 15'b011101111011110);
      check_val("t4_nwords", olog.size(), 10);
      if (olog.size() == 10) begin
         for (int k = 0; k < 10; k++) begin
            check_val("t4_data", olog[k].data, 8'(8'h40 + k));
            check_val("t4_id", olog[k].id, 2);
            check_val("t4_last", olog[k].last, (k == 3 || k == 7) ? 1 : 0);
         end
      end
      check_val("t4_last_grant", u_arb4.last_grant_reg, 2);

      // ---- reset asserted mid-burst with a valid word pending ----
      sel = 1'b0;
      do_reset();
      for (int k = 0; k < 10; k++) begin
         fq[0].push_back(8'(8'h70 + k));
         fq[1].push_back(8'(8'h80 + k));
      end
      release_reset();
      for (int k = 0; k < 3; k++) tick();
      check_val("t5_pre_valid", o_valid_obs, 1);
      check_val("t5_pre_busy", busy_obs, 1);
      rrst = 1'b1;
      #1;
      tick();
      check_val("t5_rst_valid", o_valid_obs, 0);
      check_val("t5_rst_rinc", rinc_obs, 0);
      check_val("t5_rst_busy", busy_obs, 0);
      check_val("t5_rst_last_grant", u_arb8.last_grant_reg, 3);
      for (int i = 0; i < N; i++) fq[i].delete();
      for (int k = 0; k < 10; k++) begin
         fq[0].push_back(8'(8'h50 + k));
         fq[1].push_back(8'(8'h60 + k));
      end
      release_reset();
      for (int k = 0; k < 25; k++) tick();
      check_val("t5_nwords_ge9", (olog.size() >= 9) ? 1 : 0, 1);
      if (olog.size() >= 9) begin
         check_val("t5_first_id", olog[0].id, 0);
         check_val("t5_first_data", olog[0].data, 8'h50);
         check_val("t5_w7_last", olog[7].last, 1);
         check_val("t5_w8_id", olog[8].id, 1);
         check_val("t5_w8_data", olog[8].data, 8'h60);
      end

      check_val("rinc_protocol", rinc_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
